// File: rtl/cache_pkg.sv
// Shared types and default widths for the L1 requester and its tag store.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      L2_REQ  = 2'd1,
      L2_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam int DEF_ADDR_WIDTH = 11;
   localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/l1_tag_store.sv
// Direct-mapped L1 storage: valid/tag/data arrays, combinational lookup,
// single write port used for fills, and a whole-cache flush.
module l1_tag_store #(
   parameter int L1_LINES   = 8,
   parameter int IDX_W      = 3,
   parameter int TAG_W      = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [IDX_W-1:0]      rd_index,
   input  logic [TAG_W-1:0]      rd_tag,
   output logic                  rd_hit,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [L1_LINES-1:0]   valid_r;
   logic [TAG_W-1:0]      tag_r  [L1_LINES];
   logic [DATA_WIDTH-1:0] data_r [L1_LINES];

   // Line storage; flush wins over a fill (they never coincide in practice).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= '0;
         for (int i = 0; i < L1_LINES; i++) begin
            tag_r[i]  <= '0;
            data_r[i] <= '0;
         end
      end else if (flush) begin
         valid_r <= '0;
      end else if (wr_en) begin
         valid_r[wr_index] <= 1'b1;
         tag_r[wr_index]   <= wr_tag;
         data_r[wr_index]  <= wr_data;
      end
   end

   // Lookup of the presented index/tag.
   always_comb begin
      rd_hit  = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
      rd_data = data_r[rd_index];
   end

endmodule

// File: rtl/cache_l1_requester.sv
// L1 read requester: hits answer in one cycle, misses fetch from L2 and fill.
// Optional hit/miss statistics are built only when L1_STATS_EN is defined.
module cache_l1_requester
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int L1_LINES   = 8,
   parameter int BLOCK_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_flush,
   output logic                  cpu_ready,
   output logic                  cpu_resp_valid,
   output logic [DATA_WIDTH-1:0] cpu_resp_data,
   output logic                  cpu_resp_hit,
   output logic                  l2_read,
   output logic [ADDR_WIDTH-1:0] l2_addr,
   input  logic [DATA_WIDTH-1:0] l2_read_data,
   input  logic                  l2_hit,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
);

   localparam int OFF_W = $clog2(BLOCK_SIZE);
   localparam int IDX_W = $clog2(L1_LINES);
   localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

   state_t                state_r, state_n;
   logic                  hit_s, miss_s, flush_s, fill_s, resp_s;
   logic                  lookup_hit_s;
   logic [DATA_WIDTH-1:0] lookup_data_s;
   logic [IDX_W-1:0]      line_idx_r;
   logic [TAG_W-1:0]      line_tag_r;
   logic [DATA_WIDTH-1:0] fill_data_r;
   logic                  l2_hit_r;
   logic                  resp_valid_r, resp_hit_r, l2_read_r;
   logic [DATA_WIDTH-1:0] resp_data_r;
   logic [ADDR_WIDTH-1:0] l2_addr_r;
   logic                  unused_s;

   l1_tag_store #(
      .L1_LINES   (L1_LINES),
      .IDX_W      (IDX_W),
      .TAG_W      (TAG_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_s),
      .rd_index (cpu_addr[OFF_W +: IDX_W]),
      .rd_tag   (cpu_addr[ADDR_WIDTH-1 -: TAG_W]),
      .rd_hit   (lookup_hit_s),
      .rd_data  (lookup_data_s),
      .wr_en    (fill_s),
      .wr_index (line_idx_r),
      .wr_tag   (line_tag_r),
      .wr_data  (l2_read_data)
   );

   // Held in reset means not ready, even though the state already reads IDLE.
   assign cpu_ready = (state_r == IDLE) && !cpu_flush && !rst;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_n;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_n = state_r;
      hit_s   = 1'b0;
      miss_s  = 1'b0;
      flush_s = 1'b0;
      fill_s  = 1'b0;
      resp_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cpu_flush) begin
               flush_s = 1'b1;
            end else if (cpu_req) begin
               if (lookup_hit_s) begin
                  hit_s = 1'b1;
               end else begin
                  miss_s  = 1'b1;
                  state_n = L2_REQ;
               end
            end else begin
               state_n = IDLE;
            end
         end
         L2_REQ:  state_n = L2_WAIT;
         L2_WAIT: begin
            fill_s  = 1'b1;
            state_n = RESP;
         end
         RESP: begin
            resp_s  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered CPU/L2 outputs, miss bookkeeping and fill capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_r <= 1'b0;
         resp_hit_r   <= 1'b0;
         resp_data_r  <= '0;
         l2_read_r    <= 1'b0;
         l2_addr_r    <= '0;
         line_idx_r   <= '0;
         line_tag_r   <= '0;
         fill_data_r  <= '0;
         l2_hit_r     <= 1'b0;
      end else begin
         resp_valid_r <= hit_s | resp_s;
         l2_read_r    <= miss_s;
         if (hit_s) begin
            resp_data_r <= lookup_data_s;
            resp_hit_r  <= 1'b1;
         end else if (resp_s) begin
            resp_data_r <= fill_data_r;
            resp_hit_r  <= 1'b0;
         end
         if (miss_s) begin
            l2_addr_r  <= cpu_addr;
            line_idx_r <= cpu_addr[OFF_W +: IDX_W];
            line_tag_r <= cpu_addr[ADDR_WIDTH-1 -: TAG_W];
         end
         if (fill_s) begin
            fill_data_r <= l2_read_data;
            l2_hit_r    <= l2_hit;
         end
      end
   end

   assign cpu_resp_valid = resp_valid_r;
   assign cpu_resp_hit   = resp_hit_r;
   assign cpu_resp_data  = resp_data_r;
   assign l2_read        = l2_read_r;
   assign l2_addr        = l2_addr_r;
   // The L2 hit flag is captured for observability only; nothing consumes it.
   assign unused_s       = l2_hit_r;

`ifdef L1_STATS_EN
   logic [15:0] hit_cnt_r, miss_cnt_r;

   // Saturating hit/miss counters, stepped on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_r  <= 16'd0;
         miss_cnt_r <= 16'd0;
      end else begin
         if (hit_s && (hit_cnt_r != 16'hFFFF))   hit_cnt_r  <= hit_cnt_r + 16'd1;
         if (miss_s && (miss_cnt_r != 16'hFFFF)) miss_cnt_r <= miss_cnt_r + 16'd1;
      end
   end

   assign hit_count  = hit_cnt_r;
   assign miss_count = miss_cnt_r;
`else
   assign hit_count  = 16'd0;
   assign miss_count = 16'd0;
`endif

endmodule
